// File: rtl/operand_fetch_stage_pkg.sv
// operand_fetch_stage_pkg: ALU control encodings, default widths and immediate sign-extension.
package operand_fetch_stage_pkg;
    localparam int OF_DATA_W = 32;
    localparam int OF_ADDR_W = 5;
    localparam int OF_IMM_W  = 16;

    typedef enum logic [2:0] {
        GIN_AND = 3'b000,
        GIN_OR  = 3'b001,
        GIN_ADD = 3'b010,
        GIN_SLL = 3'b011,
        GIN_NOR = 3'b100,
        GIN_SUB = 3'b110,
        GIN_SLT = 3'b111
    } gin_t;

    function automatic logic [OF_DATA_W-1:0] sext(input logic [OF_IMM_W-1:0] imm);
        return {{(OF_DATA_W-OF_IMM_W){imm[OF_IMM_W-1]}}, imm};
    endfunction
endpackage

// File: rtl/mips_regfile.sv
// mips_regfile: 2-read/1-write register file, R0 hardwired to zero.
// OPERAND_BYPASS_EN forwards a same-cycle writeback to the read ports.
module mips_regfile
    import operand_fetch_stage_pkg::*;
#(
    parameter int DATA_W = OF_DATA_W,
    parameter int ADDR_W = OF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data
);
    logic [DATA_W-1:0] regs [2**ADDR_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
        else if (wb_en && wb_addr != '0)
            regs[wb_addr] <= wb_data;
    end

`ifdef OPERAND_BYPASS_EN
    assign rs_data = (rs == '0) ? '0 : (wb_en && wb_addr == rs) ? wb_data : regs[rs];
    assign rt_data = (rt == '0) ? '0 : (wb_en && wb_addr == rt) ? wb_data : regs[rt];
`else
    assign rs_data = (rs == '0) ? '0 : regs[rs];
    assign rt_data = (rt == '0) ? '0 : regs[rt];
`endif
endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: register read, operand select and ID/EX register feeding the ALU.
// Build option OPERAND_BYPASS_EN enables same-cycle writeback forwarding in the register file.
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
#(
    parameter int DATA_W = OF_DATA_W,
    parameter int ADDR_W = OF_ADDR_W,
    parameter int IMM_W  = OF_IMM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic [IMM_W-1:0]  id_imm,
    input  logic [4:0]        id_shamt,
    input  logic              id_use_imm,
    input  logic              id_use_shamt,
    input  logic [2:0]        id_gin,
    input  logic              flush,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [2:0]        ex_gin,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data
);
    logic [DATA_W-1:0] rs_data, rt_data, op_a, op_b;
    logic              xfer;

    mips_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .wb_en  (wb_en),
        .wb_addr(wb_addr),
        .wb_data(wb_data),
        .rs     (id_rs),
        .rt     (id_rt),
        .rs_data(rs_data),
        .rt_data(rt_data)
    );

    assign id_ready = !flush && (!ex_valid || ex_ready);
    assign xfer     = id_valid && id_ready;
    assign op_a     = id_use_shamt ? {{(DATA_W-5){1'b0}}, id_shamt} : rs_data;
    assign op_b     = id_use_imm ? sext(id_imm) : rt_data;

    // Flush outranks stall; data registers only move on a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_gin   <= 3'b000;
        end else begin
            ex_valid <= flush ? 1'b0 : xfer ? 1'b1 : ex_ready ? 1'b0 : ex_valid;
            if (xfer) begin
                ex_a   <= op_a;
                ex_b   <= op_b;
                ex_gin <= id_gin;
            end
        end
    end
endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage: directed vectors with hand-computed expectations for operand_fetch_stage.
// Bypass expectations follow OPERAND_BYPASS_EN.
module tb_operand_fetch_stage;
    import operand_fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_ready, id_use_imm, id_use_shamt, flush;
    logic [4:0]  id_rs, id_rt, id_shamt, wb_addr;
    logic [15:0] id_imm;
    logic [2:0]  id_gin, ex_gin;
    logic        ex_valid, ex_ready, wb_en;
    logic [31:0] ex_a, ex_b, wb_data;
    int          errors = 0;
    int          checks = 0;

    operand_fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
        .id_rs(id_rs), .id_rt(id_rt), .id_imm(id_imm), .id_shamt(id_shamt),
        .id_use_imm(id_use_imm), .id_use_shamt(id_use_shamt), .id_gin(id_gin),
        .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_a(ex_a),
        .ex_b(ex_b), .ex_gin(ex_gin), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [2:0] gin);
        id_valid = 1'b1;
        id_rs    = rs;
        id_rt    = rt;
        id_gin   = gin;
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        wb_en   = 1'b1;
        wb_addr = addr;
        wb_data = data;
        tick();
        wb_en   = 1'b0;
    endtask

    initial begin
        logic [31:0] r7_exp;
        rst_n = 1'b0; id_valid = 0; id_rs = 0; id_rt = 0; id_imm = 0; id_shamt = 0;
        id_use_imm = 0; id_use_shamt = 0; id_gin = 0; flush = 0; ex_ready = 1;
        wb_en = 0; wb_addr = 0; wb_data = 0;
        tick(); tick();
        check("rst_valid", {31'b0, ex_valid}, 32'd0);
        check("rst_a", ex_a, 32'd0);
        check("rst_b", ex_b, 32'd0);
        check("rst_gin", {29'b0, ex_gin}, 32'd0);
        rst_n = 1'b1;
        tick();

        write_reg(5'd5, 32'h0000_0007);
        write_reg(5'd6, 32'hFFFF_FFFE);

        issue(5'd5, 5'd6, GIN_SUB);
        #1 check("rdy_idle", {31'b0, id_ready}, 32'd1);
        tick();
        check("rr_valid", {31'b0, ex_valid}, 32'd1);
        check("rr_a", ex_a, 32'h0000_0007);
        check("rr_b", ex_b, 32'hFFFF_FFFE);
        check("rr_gin", {29'b0, ex_gin}, 32'd6);

        issue(5'd5, 5'd0, GIN_ADD);
        id_use_imm = 1'b1; id_imm = 16'h8000;
        tick();
        check("imm_a", ex_a, 32'h0000_0007);
        check("imm_b", ex_b, 32'hFFFF_8000);

        issue(5'd0, 5'd5, GIN_SLL);
        id_use_imm = 1'b0; id_use_shamt = 1'b1; id_shamt = 5'd4;
        tick();
        check("sh_a", ex_a, 32'd4);
        check("sh_b", ex_b, 32'd7);
        check("sh_gin", {29'b0, ex_gin}, 32'd3);

        issue(5'd6, 5'd6, GIN_OR);
        id_use_imm = 1'b1; id_shamt = 5'd9; id_imm = 16'h0012;
        tick();
        check("both_a", ex_a, 32'd9);
        check("both_b", ex_b, 32'h0000_0012);

        id_use_imm = 1'b0; id_use_shamt = 1'b0;
        issue(5'd6, 5'd5, GIN_AND);
        ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("stall_rdy", {31'b0, id_ready}, 32'd0);
            tick();
            check("stall_valid", {31'b0, ex_valid}, 32'd1);
            check("stall_a", ex_a, 32'd9);
            check("stall_b", ex_b, 32'h0000_0012);
            check("stall_gin", {29'b0, ex_gin}, 32'd1);
        end
        ex_ready = 1'b1;
        #1 check("unstall_rdy", {31'b0, id_ready}, 32'd1);
        tick();
        check("unstall_a", ex_a, 32'hFFFF_FFFE);
        check("unstall_b", ex_b, 32'd7);
        check("unstall_gin", {29'b0, ex_gin}, 32'd0);

        issue(5'd5, 5'd5, GIN_SLT);
        flush = 1'b1;
        #1 check("flush_rdy", {31'b0, id_ready}, 32'd0);
        tick();
        flush = 1'b0; id_valid = 1'b0;
        check("flush_valid", {31'b0, ex_valid}, 32'd0);
        check("flush_hold_a", ex_a, 32'hFFFF_FFFE);

        write_reg(5'd0, 32'h0000_DEAD);
        issue(5'd0, 5'd0, GIN_NOR);
        tick();
        check("r0_a", ex_a, 32'd0);
        check("r0_b", ex_b, 32'd0);

        write_reg(5'd7, 32'h0000_0055);
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h0000_1234;
        issue(5'd7, 5'd7, GIN_ADD);
`ifdef OPERAND_BYPASS_EN
        r7_exp = 32'h0000_1234;
`else
        r7_exp = 32'h0000_0055;
`endif
        tick();
        wb_en = 1'b0;
        check("byp_a", ex_a, r7_exp);
        check("byp_b", ex_b, r7_exp);
        tick();
        check("r7_after", ex_a, 32'h0000_1234);

        ex_ready = 1'b0;
        issue(5'd5, 5'd6, GIN_SUB);
        tick();
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_AAAA;
        #2 rst_n = 1'b0;
        #1 check("arst_valid", {31'b0, ex_valid}, 32'd0);
        check("arst_a", ex_a, 32'd0);
        check("arst_b", ex_b, 32'd0);
        tick();
        rst_n = 1'b1; wb_en = 1'b0; ex_ready = 1'b1;
        issue(5'd5, 5'd6, GIN_ADD);
        tick();
        check("post_rst_valid", {31'b0, ex_valid}, 32'd1);
        check("post_rst_r5", ex_a, 32'd0);
        check("post_rst_r6", ex_b, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
